// File: rtl/bram_reader_pkg.sv
// Shared types and sizing for the firstConv BRAM stream reader.
// The reader FSM states and the depth of its output skid FIFO live here.
package bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    // Smallest power-of-two depth that sustains one word per cycle under the credit rule
    localparam int FIFO_DEPTH      = 4;
    localparam int FIFO_COUNT_BITS = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO with occupancy count; DEPTH must be a power of two >= 2.
// Simultaneous push and pop are both honoured, including when full.
module stream_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [CNT_BITS-1:0] FULL_COUNT = CNT_BITS'(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                do_push;
    logic                do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Walks an address window of the firstConv RAM and turns its 1-cycle-latency
// read port into a valid/ready stream, throttling reads under backpressure.
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [RAM_ADDR_BITS:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic [RAM_WIDTH-1:0]     m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     m_last
);

    localparam int CNT_W = RAM_ADDR_BITS + 1;
    localparam int OCC_W = FIFO_COUNT_BITS + 1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [OCC_W-1:0] OCC_LIMIT  = OCC_W'(FIFO_DEPTH);

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] base_q, base_d;
    logic [CNT_W-1:0]         length_q, length_d;
    logic [CNT_W-1:0]         issued_q, issued_d;
    logic [CNT_W-1:0]         sent_q, sent_d;
    logic                     ram_enable_q, ram_enable_d;
    logic [RAM_ADDR_BITS-1:0] address_q, address_d;
    logic                     pending_q, pending_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                       fifo_push;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [FIFO_COUNT_BITS-1:0] fifo_count;
    logic [RAM_WIDTH-1:0]       fifo_head;
    logic                       handshake;
    logic                       final_word;
    logic                       last_handshake;
    logic [OCC_W-1:0]           occupancy_next;

    assign handshake      = !fifo_empty && m_ready;
    assign final_word     = ((sent_q + CNT_ONE) == length_q);
    assign last_handshake = handshake && final_word;
    assign fifo_push      = pending_q && (!fifo_full || handshake);

    stream_fifo #(
        .WIDTH (RAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (ram_data),
        .pop       (handshake),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ram_enable is registered, so the credit check is evaluated on next-cycle
    // occupancy: FIFO after this edge plus the read that becomes pending.
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        length_d  = length_q;
        issued_d  = issued_q + CNT_W'(ram_enable_q);
        sent_d    = sent_q + CNT_W'(handshake);
        pending_d = ram_enable_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    length_d = length;
                    issued_d = '0;
                    sent_d   = '0;
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last_handshake) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (issued_q == length_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (last_handshake) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        occupancy_next = OCC_W'(fifo_count) + OCC_W'(pending_q) - OCC_W'(handshake)
                       + OCC_W'(ram_enable_q);
        ram_enable_d   = (state_d == RUN) && (issued_d < length_d) && (occupancy_next < OCC_LIMIT);
        address_d      = ram_enable_d ? (base_d + issued_d[RAM_ADDR_BITS-1:0]) : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            base_q       <= '0;
            length_q     <= '0;
            issued_q     <= '0;
            sent_q       <= '0;
            ram_enable_q <= 1'b0;
            address_q    <= '0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            length_q     <= length_d;
            issued_q     <= issued_d;
            sent_q       <= sent_d;
            ram_enable_q <= ram_enable_d;
            address_q    <= address_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign ram_enable   = ram_enable_q;
    assign write_enable = 1'b0;
    assign address      = address_q;
    assign m_valid      = !fifo_empty;
    assign m_data       = fifo_empty ? '0 : fifo_head;
    assign m_last       = !fifo_empty && final_word;

endmodule
